// File: rtl/ahb_master_req_gen_pkg.sv
// Shared AHB types for the master-side request generator.
//   htrans_type  - master transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_type  - AHB burst encoding
//   hresp_type   - slave response (OKAY/ERROR)
//   req_state_e  - request generator FSM states
//   burst_limit  - last beat index (0-based) of a fixed-length burst
package ahb_master_req_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_type;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_ERR1,
        S_ERR2
    } req_state_e;

    // INCR has no limit; its value here is never consulted.
    function automatic logic [3:0] burst_limit(input hburst_type burst);
        case (burst)
            WRAP4,  INCR4:  burst_limit = 4'd3;
            WRAP8,  INCR8:  burst_limit = 4'd7;
            WRAP16, INCR16: burst_limit = 4'd15;
            default:        burst_limit = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_master_req_gen_decoder.sv
// Combinational address decoder: haddr -> target slave index + valid.
//   haddr_i     - master address
//   slave_id_o  - low SLAVE_ID_BIT bits of the slave field
//   valid_o     - 1 when the whole field above SLAVE_ID_LSB names an existing slave
// The full upper field is compared, so an address whose slave field aliases a
// real index in its low bits (e.g. 0x5000_0000 with 4 slaves) is still unmapped.
module ahb_slave_decoder #(
    parameter int SLAVE_NUM    = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int SLAVE_ID_LSB = 28,
    parameter int SLAVE_ID_BIT = $clog2(SLAVE_NUM)
) (
    input  logic [ADDR_WIDTH-1:0]   haddr_i,
    output logic [SLAVE_ID_BIT-1:0] slave_id_o,
    output logic                    valid_o
);

    localparam int FIELD_W = ADDR_WIDTH - SLAVE_ID_LSB;

    logic [FIELD_W-1:0] slave_field;
    logic               unused_addr_bits;

    assign slave_field      = haddr_i[ADDR_WIDTH-1:SLAVE_ID_LSB];
    assign slave_id_o       = slave_field[SLAVE_ID_BIT-1:0];
    assign valid_o          = (int'(slave_field) < SLAVE_NUM);
    assign unused_addr_bits = ^haddr_i[SLAVE_ID_LSB-1:0];

endmodule

// File: rtl/ahb_master_req_gen.sv
// Master-side AHB request generator.
//   hclk/hreset  - clock, synchronous active-high reset
//   htrans/haddr/hburst - master transfer request
//   hgrant       - per-slave grant to this master (already masked by hwait)
//   hreq         - registered one-hot request to the slave arbiters
//   hburst_req   - latched burst type for the arbiter monitor
//   hslave_id    - latched target slave for the data-path mux
//   hready_out   - ready/stall to the master
//   hresp        - OKAY/ERROR to the master (two-cycle ERROR for unmapped addresses)
module ahb_master_req_gen
    import ahb_master_req_gen_pkg::*;
#(
    parameter int SLAVE_NUM    = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int SLAVE_ID_LSB = 28,
    parameter int SLAVE_ID_BIT = $clog2(SLAVE_NUM)
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  htrans_type              htrans,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  hburst_type              hburst,
    input  logic [SLAVE_NUM-1:0]    hgrant,
    output logic [SLAVE_NUM-1:0]    hreq,
    output hburst_type              hburst_req,
    output logic [SLAVE_ID_BIT-1:0] hslave_id,
    output logic                    hready_out,
    output hresp_type               hresp
);

    req_state_e              state_q;
    logic [SLAVE_NUM-1:0]    hreq_q;
    hburst_type              hburst_q;
    logic [SLAVE_ID_BIT-1:0] hslave_id_q;
    logic                    hready_q;
    hresp_type               hresp_q;
    logic [3:0]              count_q;

    logic [SLAVE_ID_BIT-1:0] dec_id;
    logic                    dec_valid;

    ahb_slave_decoder #(
        .SLAVE_NUM   (SLAVE_NUM),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SLAVE_ID_LSB(SLAVE_ID_LSB),
        .SLAVE_ID_BIT(SLAVE_ID_BIT)
    ) u_decoder (
        .haddr_i   (haddr),
        .slave_id_o(dec_id),
        .valid_o   (dec_valid)
    );

    logic grant_sel;
    logic beat_accept;
    logic open_burst;
    logic last_beat;
    logic incr_end;
    logic incr_switch;

    // Only the grant of the latched target matters; other bits are ignored.
    assign grant_sel   = hgrant[hslave_id_q];
    assign beat_accept = grant_sel && (htrans == NONSEQ || htrans == SEQ);
    assign open_burst  = (hburst_q == INCR);
    assign last_beat   = !open_burst && beat_accept && (count_q == burst_limit(hburst_q));
    assign incr_end    = open_burst && grant_sel && (htrans == IDLE);
    // A new NONSEQ elsewhere ends an INCR burst; the master is held this cycle
    // and re-requests from IDLE.
    assign incr_switch = open_burst && (htrans == NONSEQ) &&
                         (!dec_valid || dec_id != hslave_id_q);

    // In XFER the master's ready follows the live grant (grant drops stall it
    // the same cycle); in every other state it is the registered value.
    assign hready_out = (state_q == S_XFER) ? (grant_sel && !incr_switch) : hready_q;
    assign hreq       = hreq_q;
    assign hburst_req = hburst_q;
    assign hslave_id  = hslave_id_q;
    assign hresp      = hresp_q;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge hclk) begin
        // NOTE: reset is synchronous; hreset is only seen at a rising edge.
        if (hreset) begin
            state_q     <= S_IDLE;
            hreq_q      <= '0;
            hburst_q    <= SINGLE;
            hslave_id_q <= '0;
            hready_q    <= 1'b1;
            hresp_q     <= OKAY;
            count_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (htrans == NONSEQ) begin
                        hready_q <= 1'b0;
                        if (dec_valid) begin
                            state_q         <= S_REQ;
                            hslave_id_q     <= dec_id;
                            hburst_q        <= hburst;
                            count_q         <= '0;
                            hreq_q          <= '0;
                            hreq_q[dec_id]  <= 1'b1;
                        end else begin
                            state_q <= S_ERR1;
                            hresp_q <= ERROR;
                        end
                    end
                end
                S_REQ: begin
                    if (grant_sel) begin
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (incr_switch || incr_end || last_beat) begin
                        state_q  <= S_IDLE;
                        hreq_q   <= '0;
                        hready_q <= 1'b1;
                    end else if (beat_accept) begin
                        count_q <= count_q + 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q  <= S_ERR2;
                    hready_q <= 1'b1;
                end
                S_ERR2: begin
                    state_q <= S_IDLE;
                    hresp_q <= OKAY;
                end
                default: begin
                    state_q  <= S_IDLE;
                    hreq_q   <= '0;
                    hready_q <= 1'b1;
                    hresp_q  <= OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_req_gen.sv
// Self-checking bench for ahb_master_req_gen: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model (owner slave, beats remaining, error cycles left).
module tb_ahb_master_req_gen;
    import ahb_master_req_gen_pkg::*;

    logic        hclk   = 1'b0;
    logic        hreset = 1'b1;
    htrans_type  htrans = IDLE;
    logic [31:0] haddr  = '0;
    hburst_type  hburst = SINGLE;
    logic [3:0]  hgrant = '0;

    logic [3:0]  hreq;
    hburst_type  hburst_req;
    logic [1:0]  hslave_id;
    logic        hready_out;
    hresp_type   hresp;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    always #5 hclk = ~hclk;

    ahb_master_req_gen #(
        .SLAVE_NUM   (4),
        .ADDR_WIDTH  (32),
        .SLAVE_ID_LSB(28)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .htrans    (htrans),
        .haddr     (haddr),
        .hburst    (hburst),
        .hgrant    (hgrant),
        .hreq      (hreq),
        .hburst_req(hburst_req),
        .hslave_id (hslave_id),
        .hready_out(hready_out),
        .hresp     (hresp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_owner = -1;   // slave currently requested, -1 = none
    bit         m_wait  = 1'b0; // request raised, grant not yet seen
    int         m_err   = 0;    // ERROR response cycles still to show
    int         m_left  = 0;    // beats remaining, -1 = open-ended INCR
    hburst_type m_burst = SINGLE;
    int         m_id    = 0;

    function automatic int beats_of(input hburst_type b);
        case (b)
            SINGLE:        return 1;
            INCR:          return -1;
            WRAP4, INCR4:  return 4;
            WRAP8, INCR8:  return 8;
            default:       return 16;
        endcase
    endfunction

    function automatic int slave_of(input logic [31:0] a);
        return int'(a[31:28]);
    endfunction

    function automatic bit leaving_incr();
        return m_owner >= 0 && !m_wait && m_left < 0 &&
               htrans == NONSEQ && slave_of(haddr) != m_owner;
    endfunction

    function automatic logic exp_ready();
        if (m_err == 2) return 1'b0;
        if (m_err == 1) return 1'b1;
        if (m_owner < 0) return 1'b1;
        if (m_wait) return 1'b0;
        if (leaving_incr()) return 1'b0;
        return hgrant[m_owner];
    endfunction

    always @(posedge hclk) begin
        if (hreset) begin
            m_owner = -1; m_wait = 1'b0; m_err = 0; m_left = 0;
            m_burst = SINGLE; m_id = 0;
        end else if (m_err > 0) begin
            m_err = m_err - 1;
        end else if (m_owner < 0) begin
            if (htrans == NONSEQ) begin
                if (slave_of(haddr) < 4) begin
                    m_owner = slave_of(haddr); m_id = m_owner; m_burst = hburst;
                    m_wait  = 1'b1; m_left = beats_of(hburst);
                end else begin
                    m_err = 2;
                end
            end
        end else if (m_wait) begin
            if (hgrant[m_owner]) m_wait = 1'b0;
        end else if (m_left < 0) begin
            if (leaving_incr() || (htrans == IDLE && hgrant[m_owner])) m_owner = -1;
        end else if (hgrant[m_owner] && (htrans == NONSEQ || htrans == SEQ)) begin
            m_left = m_left - 1;
            if (m_left == 0) m_owner = -1;
        end
    end

    // One compare process: every cycle, away from the rising edge.
    always @(negedge hclk) begin
        #1;
        if (check_en) begin
            check("model_hreq", 32'(hreq), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_hready", 32'(hready_out), 32'(exp_ready()));
            check("model_hresp", 32'(hresp), (m_err > 0) ? 32'(ERROR) : 32'(OKAY));
            check("model_hburst_req", 32'(hburst_req), 32'(m_burst));
            check("model_hslave_id", 32'(hslave_id), 32'(m_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input htrans_type t, input logic [31:0] a, input hburst_type b,
                         input logic [3:0] g, input logic r);
        @(negedge hclk);
        htrans = t; haddr = a; hburst = b; hgrant = g; hreset = r;
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] rq, input logic rd,
                              input hresp_type rp);
        check({tag, "_hreq"}, 32'(hreq), 32'(rq));
        check({tag, "_hready"}, 32'(hready_out), 32'(rd));
        check({tag, "_hresp"}, 32'(hresp), 32'(rp));
    endtask

    initial begin
        // Reset
        drive(IDLE, 32'h0, SINGLE, 4'h0, 1'b1);
        drive(IDLE, 32'h0, SINGLE, 4'h0, 1'b1);
        check_en = 1'b1;
        drive(IDLE, 32'h0, SINGLE, 4'h0, 1'b0);
        expect_out("rst", 4'b0000, 1'b1, OKAY);
        check("rst_hburst_req", 32'(hburst_req), 32'(SINGLE));
        check("rst_hslave_id", 32'(hslave_id), 32'd0);

        // 1: SINGLE to slave 1, grant arrives in the third stalled cycle
        drive(NONSEQ, 32'h1000_0000, SINGLE, 4'b0000, 1'b0); expect_out("t1a", 4'b0000, 1'b1, OKAY);
        drive(NONSEQ, 32'h1000_0000, SINGLE, 4'b0000, 1'b0); expect_out("t1b", 4'b0010, 1'b0, OKAY);
        drive(NONSEQ, 32'h1000_0000, SINGLE, 4'b0000, 1'b0); expect_out("t1c", 4'b0010, 1'b0, OKAY);
        drive(NONSEQ, 32'h1000_0000, SINGLE, 4'b0010, 1'b0); expect_out("t1d", 4'b0010, 1'b0, OKAY);
        drive(NONSEQ, 32'h1000_0000, SINGLE, 4'b0010, 1'b0); expect_out("t1e", 4'b0010, 1'b1, OKAY);
        check("t1_hslave_id", 32'(hslave_id), 32'd1);
        drive(IDLE, 32'h0, SINGLE, 4'b0000, 1'b0);           expect_out("t1f", 4'b0000, 1'b1, OKAY);

        // 2: INCR4 to slave 2, grant dropped for 2 cycles on beat 2
        drive(NONSEQ, 32'h2000_0000, INCR4, 4'b0100, 1'b0); expect_out("t2a", 4'b0000, 1'b1, OKAY);
        drive(NONSEQ, 32'h2000_0000, INCR4, 4'b0100, 1'b0); expect_out("t2b", 4'b0100, 1'b0, OKAY);
        drive(NONSEQ, 32'h2000_0000, INCR4, 4'b0100, 1'b0); expect_out("t2_beat1", 4'b0100, 1'b1, OKAY);
        drive(SEQ, 32'h2000_0004, INCR4, 4'b0000, 1'b0);    expect_out("t2_drop1", 4'b0100, 1'b0, OKAY);
        drive(SEQ, 32'h2000_0004, INCR4, 4'b0000, 1'b0);    expect_out("t2_drop2", 4'b0100, 1'b0, OKAY);
        drive(SEQ, 32'h2000_0004, INCR4, 4'b0100, 1'b0);    expect_out("t2_beat2", 4'b0100, 1'b1, OKAY);
        drive(SEQ, 32'h2000_0008, INCR4, 4'b0100, 1'b0);    expect_out("t2_beat3", 4'b0100, 1'b1, OKAY);
        drive(SEQ, 32'h2000_000C, INCR4, 4'b0100, 1'b0);    expect_out("t2_beat4", 4'b0100, 1'b1, OKAY);
        check("t2_hburst_req", 32'(hburst_req), 32'(INCR4));
        drive(IDLE, 32'h0, SINGLE, 4'b0000, 1'b0);          expect_out("t2_end", 4'b0000, 1'b1, OKAY);

        // 3: unmapped address -> two-cycle ERROR
        drive(NONSEQ, 32'h5000_0000, SINGLE, 4'b1111, 1'b0); expect_out("t3a", 4'b0000, 1'b1, OKAY);
        drive(IDLE, 32'h0, SINGLE, 4'b1111, 1'b0);           expect_out("t3_err1", 4'b0000, 1'b0, ERROR);
        drive(IDLE, 32'h0, SINGLE, 4'b1111, 1'b0);           expect_out("t3_err2", 4'b0000, 1'b1, ERROR);
        drive(IDLE, 32'h0, SINGLE, 4'b1111, 1'b0);           expect_out("t3_done", 4'b0000, 1'b1, OKAY);

        // 4: INCR to slave 0, then NONSEQ to slave 3
        drive(NONSEQ, 32'h0000_0000, INCR, 4'b0001, 1'b0); expect_out("t4a", 4'b0000, 1'b1, OKAY);
        drive(NONSEQ, 32'h0000_0000, INCR, 4'b0001, 1'b0); expect_out("t4b", 4'b0001, 1'b0, OKAY);
        drive(SEQ, 32'h0000_0004, INCR, 4'b0001, 1'b0);    expect_out("t4c", 4'b0001, 1'b1, OKAY);
        drive(NONSEQ, 32'h3000_0000, INCR, 4'b0001, 1'b0); expect_out("t4_switch", 4'b0001, 1'b0, OKAY);
        drive(NONSEQ, 32'h3000_0000, INCR, 4'b1000, 1'b0); expect_out("t4_gap", 4'b0000, 1'b1, OKAY);
        drive(NONSEQ, 32'h3000_0000, INCR, 4'b1000, 1'b0); expect_out("t4_s3", 4'b1000, 1'b0, OKAY);
        drive(IDLE, 32'h0, INCR, 4'b1000, 1'b0);           expect_out("t4_xfer", 4'b1000, 1'b1, OKAY);
        drive(IDLE, 32'h0, SINGLE, 4'b0000, 1'b0);         expect_out("t4_end", 4'b0000, 1'b1, OKAY);

        // 5: reset in the middle of an INCR8 burst
        drive(NONSEQ, 32'h1000_0000, INCR8, 4'b0010, 1'b0); expect_out("t5a", 4'b0000, 1'b1, OKAY);
        drive(NONSEQ, 32'h1000_0000, INCR8, 4'b0010, 1'b0); expect_out("t5b", 4'b0010, 1'b0, OKAY);
        drive(SEQ, 32'h1000_0004, INCR8, 4'b0010, 1'b0);    expect_out("t5c", 4'b0010, 1'b1, OKAY);
        check("t5_hburst_req", 32'(hburst_req), 32'(INCR8));
        drive(SEQ, 32'h1000_0008, INCR8, 4'b0010, 1'b1);    expect_out("t5_rst", 4'b0010, 1'b1, OKAY);
        drive(IDLE, 32'h0, SINGLE, 4'b0000, 1'b0);          expect_out("t5_after", 4'b0000, 1'b1, OKAY);
        check("t5_hburst_req_rst", 32'(hburst_req), 32'(SINGLE));

        // 6: WRAP16 with BUSY before beats 5 and 9
        drive(NONSEQ, 32'h2000_0000, WRAP16, 4'b0100, 1'b0); expect_out("t6a", 4'b0000, 1'b1, OKAY);
        drive(NONSEQ, 32'h2000_0000, WRAP16, 4'b0100, 1'b0); expect_out("t6b", 4'b0100, 1'b0, OKAY);
        for (int c = 0; c < 18; c++) begin
            htrans_type t;
            t = (c == 4 || c == 9) ? BUSY : ((c == 0) ? NONSEQ : SEQ);
            drive(t, 32'h2000_0000, WRAP16, 4'b0100, 1'b0);
            expect_out("t6_burst", 4'b0100, 1'b1, OKAY);
            check("t6_hburst_req", 32'(hburst_req), 32'(WRAP16));
        end
        drive(IDLE, 32'h0, SINGLE, 4'b0000, 1'b0); expect_out("t6_end", 4'b0000, 1'b1, OKAY);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            htrans_type  t;
            hburst_type  b;
            logic [31:0] a;
            logic [3:0]  g;
            logic        r;
            case ($urandom_range(0, 7))
                0:       t = IDLE;
                1:       t = BUSY;
                2, 3:    t = NONSEQ;
                default: t = SEQ;
            endcase
            b = hburst_type'($urandom_range(0, 7));
            a = {4'($urandom_range(0, 5)), 28'($urandom)};
            g = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            r = ($urandom_range(0, 299) == 0);
            drive(t, a, b, g, r);
        end

        drive(IDLE, 32'h0, SINGLE, 4'h0, 1'b0);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
